w_stream_tx: RTL and testbench

W_STREAM_TX -- requirements
Module: w_stream_tx

---
 rtl/w_stream_tx.sv | 116 +++++++++++
 tb/tb_w_stream_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/w_stream_tx.sv
// Serializes WIDTH-bit words MSB first onto a single-bit stream.
// Also reports the length of the current run of equal bits, saturating at RUN_LEN.
module w_stream_tx #(
    parameter int WIDTH   = 8,
    parameter int RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             w,
    output logic             w_valid,
    output logic [2:0]       run_len,
    output logic             run_hit
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [2:0]    RUN_MAX  = 3'(RUN_LEN);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sr_r;
    logic [CW-1:0]    cnt_r;

    logic             last_s;
    logic             load_s;
    logic             next_bit_s;
    logic [2:0]       run_next_s;

    // Handshake qualification and the run length the next transmitted bit will carry
    always_comb begin
        last_s     = (state_r == SHIFT) && (cnt_r == LAST_IDX);
        data_ready = (state_r == IDLE) || last_s;
        load_s     = data_valid && data_ready;
        next_bit_s = load_s ? data_in[WIDTH-1] : sr_r[WIDTH-1];
        // A run continues only if the previous cycle actually carried a bit
        if (!w_valid) begin
            run_next_s = 3'd1;
        end else if (next_bit_s != w) begin
            run_next_s = 3'd1;
        end else if (run_len >= RUN_MAX) begin
            run_next_s = RUN_MAX;
        end else begin
            run_next_s = run_len + 3'd1;
        end
    end

    assign run_hit = (run_len == RUN_MAX);

    // Transmit FSM: word capture, shifting, and registered stream outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            sr_r    <= '0;
            cnt_r   <= '0;
            w       <= 1'b0;
            w_valid <= 1'b0;
            run_len <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        state_r <= SHIFT;
                        sr_r    <= {data_in[WIDTH-2:0], 1'b0};
                        cnt_r   <= CW'(0);
                        w       <= data_in[WIDTH-1];
                        w_valid <= 1'b1;
                        run_len <= run_next_s;
                    end else begin
                        w       <= 1'b0;
                        w_valid <= 1'b0;
                        run_len <= 3'd0;
                    end
                end
                SHIFT: begin
                    if (load_s) begin
                        // Back-to-back word: the MSB follows the previous LSB with no gap
                        sr_r    <= {data_in[WIDTH-2:0], 1'b0};
                        cnt_r   <= CW'(0);
                        w       <= data_in[WIDTH-1];
                        w_valid <= 1'b1;
                        run_len <= run_next_s;
                    end else if (last_s) begin
                        state_r <= IDLE;
                        sr_r    <= '0;
                        cnt_r   <= CW'(0);
                        w       <= 1'b0;
                        w_valid <= 1'b0;
                        run_len <= 3'd0;
                    end else begin
                        sr_r    <= {sr_r[WIDTH-2:0], 1'b0};
                        cnt_r   <= cnt_r + CW'(1);
                        w       <= sr_r[WIDTH-1];
                        w_valid <= 1'b1;
                        run_len <= run_next_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    sr_r    <= '0;
                    cnt_r   <= CW'(0);
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    run_len <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_w_stream_tx.sv
// Directed bench for w_stream_tx (WIDTH=8, RUN_LEN=4).
// Observed vector per cycle is {data_ready, w_valid, w, run_len, run_hit}.
module tb_w_stream_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       w;
    logic       w_valid;
    logic [2:0] run_len;
    logic       run_hit;

    int pass_cnt = 0;
    int total_cnt = 0;

    w_stream_tx #(.WIDTH(8), .RUN_LEN(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .w          (w),
        .w_valid    (w_valid),
        .run_len    (run_len),
        .run_hit    (run_hit)
    );

    always #5 clk = ~clk;

    wire [6:0] obs = {data_ready, w_valid, w, run_len, run_hit};
    localparam logic [6:0] IDLE_OBS = 7'b1000000;

    task automatic test_reset();
        reset = 1'b1;
        data_valid = 1'b0;
        data_in = 8'h00;
        #3;
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL reset_async: got %b expected %b", obs, IDLE_OBS);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL reset_clocked: got %b expected %b", obs, IDLE_OBS);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_single_f0();
        logic [7:0] word = 8'hF0;
        logic [2:0] rl [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [6:0] exp;
        @(negedge clk);
        data_in = word;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {(i == 7), 1'b1, word[7-i], rl[i], (rl[i] == 3'd4)};
            total_cnt++;
            if (obs !== exp) $display("FAIL single_f0 bit %0d: got %b expected %b", i, obs, exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL single_f0_idle: got %b expected %b", obs, IDLE_OBS);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] word = 16'hAA55;
        logic [2:0] exp_rl;
        logic [6:0] exp;
        @(negedge clk);
        data_in = 8'hAA;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_in = 8'h55;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) data_valid = 1'b0;
            exp_rl = (i == 8) ? 3'd2 : 3'd1;
            exp = {(i == 7 || i == 15), 1'b1, word[15-i], exp_rl, 1'b0};
            total_cnt++;
            if (obs !== exp) $display("FAIL back_to_back bit %0d: got %b expected %b", i, obs, exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL back_to_back_idle: got %b expected %b", obs, IDLE_OBS);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        logic [2:0] exp_rl;
        logic [6:0] exp;
        @(negedge clk);
        data_in = 8'h00;
        data_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) data_valid = 1'b0;
            exp_rl = (i < 4) ? 3'(i + 1) : 3'd4;
            exp = {(i == 7 || i == 15), 1'b1, 1'b0, exp_rl, (i >= 3)};
            total_cnt++;
            if (obs !== exp) $display("FAIL saturate bit %0d: got %b expected %b", i, obs, exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_gap_restart();
        logic [2:0] rl [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
        logic [6:0] exp;
        @(negedge clk);
        data_in = 8'hFF;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {(i == 7), 1'b1, 1'b1, rl[i], (rl[i] == 3'd4)};
            total_cnt++;
            if (obs !== exp) $display("FAIL gap_first bit %0d: got %b expected %b", i, obs, exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL gap_idle: got %b expected %b", obs, IDLE_OBS);
        else pass_cnt++;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {(i == 7), 1'b1, 1'b1, rl[i], (rl[i] == 3'd4)};
            total_cnt++;
            if (obs !== exp) $display("FAIL gap_second bit %0d: got %b expected %b", i, obs, exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overlap();
        logic [15:0] word = 16'h813C;
        logic [2:0] rl [16] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd1,
                                3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2};
        logic [6:0] exp;
        @(negedge clk);
        data_in = 8'h81;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) begin
                data_in = 8'h3C;
                data_valid = 1'b1;
            end
            if (i == 8) data_valid = 1'b0;
            exp = {(i == 7 || i == 15), 1'b1, word[15-i], rl[i], (rl[i] == 3'd4)};
            total_cnt++;
            if (obs !== exp) $display("FAIL overlap bit %0d: got %b expected %b", i, obs, exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL overlap_idle: got %b expected %b", obs, IDLE_OBS);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] word = 8'hC3;
        logic [2:0] rl [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
        logic [6:0] exp;
        @(negedge clk);
        data_in = word;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = {1'b0, 1'b1, word[7-i], rl[i], 1'b0};
            total_cnt++;
            if (obs !== exp) $display("FAIL reset_mid bit %0d: got %b expected %b", i, obs, exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        // Now in the bit-5 cycle; reset lands between clock edges
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL reset_mid_async: got %b expected %b", obs, IDLE_OBS);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (obs !== IDLE_OBS) $display("FAIL reset_mid_after cycle %0d: got %b expected %b", i, obs, IDLE_OBS);
            else pass_cnt++;
        end
    endtask

    task automatic test_first_after_reset();
        logic [7:0] word = 8'h96;
        logic [2:0] rl [8] = '{3'd1, 3'd1, 3'd2, 3'd1, 3'd1, 3'd1, 3'd2, 3'd1};
        logic [6:0] exp;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        data_in = word;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {(i == 7), 1'b1, word[7-i], rl[i], 1'b0};
            total_cnt++;
            if (obs !== exp) $display("FAIL first_after_reset bit %0d: got %b expected %b", i, obs, exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (obs !== IDLE_OBS) $display("FAIL first_after_reset_idle: got %b expected %b", obs, IDLE_OBS);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_f0();
        test_back_to_back();
        test_saturate();
        test_gap_restart();
        test_overlap();
        test_reset_mid_word();
        test_first_after_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
